// File: rtl/fire_pkg.sv
// Shared types and sizing helpers for the multi-zone fire alarm controller.
package fire_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALARM    = 2'd1,
        SILENCED = 2'd2
    } state_e;

    // Width of the shared timer: must hold max(sprinkler_ms, silence_ms).
    function automatic int unsigned timer_width(input int unsigned sprinkler_ms,
                                                input int unsigned silence_ms);
        int unsigned m;
        m = (sprinkler_ms > silence_ms) ? sprinkler_ms : silence_ms;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fire_zone_filter.sv
// Per-zone persistence filter: a saturating run-length counter of high sensor samples.
module fire_zone_filter #(
    parameter int unsigned CONFIRM_MS = 50
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sensor_i,
    output logic conf_o
);

    localparam int unsigned CW = ($clog2(CONFIRM_MS + 1) < 1) ? 1 : $clog2(CONFIRM_MS + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any low sample restarts confirmation; saturate once confirmed.
    always_comb begin
        cnt_d = '0;
        if (sensor_i) begin
            cnt_d = (cnt_q == CW'(CONFIRM_MS)) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conf_o = (cnt_q == CW'(CONFIRM_MS));

endmodule

// File: rtl/fire_alarm_ctrl.sv
// Multi-zone fire alarm controller: zone filters, alarm/silence/re-arm FSM,
// sprinkler escalation, first-zone report and sticky zone history.
module fire_alarm_ctrl
    import fire_pkg::*;
#(
    parameter int unsigned NZONE        = 4,
    parameter int unsigned CONFIRM_MS   = 50,
    parameter int unsigned SPRINKLER_MS = 5000,
    parameter int unsigned SILENCE_MS   = 60000,
    localparam int unsigned ZW          = (NZONE > 1) ? $clog2(NZONE) : 1
) (
    input  logic             CLK1K,
    input  logic             RST,
    input  logic [NZONE-1:0] SENSOR,
    input  logic             ACK,
    input  logic             CLEAR,
    output logic             FIRE_ALARM,
    output logic             SPRINKLER,
    output logic             ZONE_VALID,
    output logic [ZW-1:0]    ZONE_ID,
    output logic [NZONE-1:0] ACTIVE_ZONES
);

    localparam int unsigned TW = timer_width(SPRINKLER_MS, SILENCE_MS);

    logic [NZONE-1:0] conf;
    logic [ZW-1:0]    first_zone;
    logic             any_conf;
    logic             new_zone;
    logic             clear_ok;

    state_e           state_q;
    logic [TW-1:0]    timer_q;
    logic             fire_q;
    logic             sprinkler_q;
    logic             valid_q;
    logic [ZW-1:0]    zone_id_q;
    logic [NZONE-1:0] active_q;

    for (genvar g = 0; g < NZONE; g++) begin : g_zone
        fire_zone_filter #(
            .CONFIRM_MS(CONFIRM_MS)
        ) u_filter (
            .clk_i   (CLK1K),
            .rst_i   (RST),
            .sensor_i(SENSOR[g]),
            .conf_o  (conf[g])
        );
    end

    // Lowest-index confirmed zone wins a same-edge tie.
    always_comb begin
        first_zone = '0;
        for (int i = int'(NZONE) - 1; i >= 0; i--) begin
            if (conf[i]) begin
                first_zone = ZW'(i);
            end
        end
    end

    assign any_conf = |conf;
    assign new_zone = |(conf & ~active_q);
    assign clear_ok = CLEAR && !any_conf;

    always_ff @(posedge CLK1K) begin
        if (RST) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            fire_q      <= 1'b0;
            sprinkler_q <= 1'b0;
            valid_q     <= 1'b0;
            zone_id_q   <= '0;
            active_q    <= '0;
        end else if (clear_ok) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            fire_q      <= 1'b0;
            sprinkler_q <= 1'b0;
            valid_q     <= 1'b0;
            zone_id_q   <= '0;
            active_q    <= '0;
        end else begin
            active_q <= active_q | conf;
            unique case (state_q)
                IDLE: begin
                    if (any_conf) begin
                        state_q   <= ALARM;
                        fire_q    <= 1'b1;
                        timer_q   <= '0;
                        zone_id_q <= first_zone;
                        valid_q   <= 1'b1;
                    end
                end
                ALARM: begin
                    if (ACK) begin
                        state_q <= SILENCED;
                        fire_q  <= 1'b0;
                        timer_q <= '0;
                    end else if (timer_q == TW'(SPRINKLER_MS - 1)) begin
                        sprinkler_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                SILENCED: begin
                    // A never-before-seen zone re-arms at once; otherwise wait out the silence window.
                    if (new_zone) begin
                        state_q <= ALARM;
                        fire_q  <= 1'b1;
                        timer_q <= '0;
                    end else if (timer_q == TW'(SILENCE_MS - 1)) begin
                        if (any_conf) begin
                            state_q <= ALARM;
                            fire_q  <= 1'b1;
                            timer_q <= '0;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    fire_q  <= 1'b0;
                end
            endcase
        end
    end

    assign FIRE_ALARM   = fire_q;
    assign SPRINKLER    = sprinkler_q;
    assign ZONE_VALID   = valid_q;
    assign ZONE_ID      = zone_id_q;
    assign ACTIVE_ZONES = active_q;

endmodule
